ped_request_ctrl: RTL and testbench

// Pedestrian-crossing request front end, directly upstream of the light-sequencing FSM.

---
 rtl/ped_request_ctrl_if.sv | 24 ++
 rtl/ped_request_ctrl.sv | 136 +++++++++++++
 tb/tb_ped_request_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ped_request_ctrl_if.sv
// Handshake bundle between the pedestrian push-button front end and its surroundings.
// The slave modport is the controller; the master modport is whoever drives the button, tick and ack.
interface ped_request_ctrl_if;
  logic       btn_n;
  logic       tick1s;
  logic       ped_ack;
  logic       ped_req;
  logic       ped_wait;
  logic       btn_level;
  logic [7:0] press_cnt;
  logic [1:0] dbg_state;

  // ped_req is a level held high until the sequencer answers with a one-cycle ped_ack pulse;
  // ped_ack seen while ped_req is low has no effect, and ped_req drops on the edge after ped_ack.
  modport master (
    output btn_n, tick1s, ped_ack,
    input  ped_req, ped_wait, btn_level, press_cnt, dbg_state
  );

  modport slave (
    input  btn_n, tick1s, ped_ack,
    output ped_req, ped_wait, btn_level, press_cnt, dbg_state
  );
endinterface

// File: rtl/ped_request_ctrl.sv
// Pedestrian request front end: synchronise and debounce the active-low button, hold a
// request until acknowledged, then enforce a hold-off during which presses are deferred.
module ped_request_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned HOLDOFF_S       = 10
) (
  input  logic              clk50M,
  input  logic              Reset,
  ped_request_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]       HOLD_LOAD = 8'(HOLDOFF_S);

  logic             s1, s2;
  logic             btn_level_q;
  logic             btn_level_d;
  logic [CNT_W-1:0] deb_cnt;
  logic             press;

  state_t           state;
  logic             deferred;
  logic [7:0]       hold_cnt;
  logic             ped_req_q;
  logic             ped_wait_q;
  logic [7:0]       press_cnt_q;
  logic [7:0]       press_cnt_inc;

  // Two-flop synchroniser; reset to the released level so no spurious press follows reset.
  always_ff @(posedge clk50M) begin
    if (Reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= bus.btn_n;
      s2 <= s1;
    end
  end

  // A new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk50M) begin
    if (Reset) begin
      btn_level_q <= 1'b1;
      btn_level_d <= 1'b1;
      deb_cnt     <= '0;
    end else begin
      btn_level_d <= btn_level_q;
      if (s2 == btn_level_q) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        btn_level_q <= s2;
        deb_cnt     <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign press         = btn_level_d & ~btn_level_q;
  assign press_cnt_inc = (press_cnt_q == 8'hFF) ? 8'hFF : press_cnt_q + 8'd1;

  always_ff @(posedge clk50M) begin
    if (Reset) begin
      state       <= IDLE;
      deferred    <= 1'b0;
      hold_cnt    <= 8'd0;
      ped_req_q   <= 1'b0;
      ped_wait_q  <= 1'b0;
      press_cnt_q <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (press) begin
            state       <= PENDING;
            ped_req_q   <= 1'b1;
            ped_wait_q  <= 1'b1;
            press_cnt_q <= press_cnt_inc;
          end
        end
        PENDING: begin
          // A press coinciding with the ack is carried into the hold-off as a deferral.
          if (bus.ped_ack) begin
            state      <= HOLDOFF;
            hold_cnt   <= HOLD_LOAD;
            ped_req_q  <= 1'b0;
            deferred   <= press;
            ped_wait_q <= press;
          end
        end
        HOLDOFF: begin
          if (hold_cnt == 8'd0) begin
            // A press landing on the exit cycle is treated like an already-deferred one.
            if (deferred | press) begin
              state       <= PENDING;
              deferred    <= 1'b0;
              ped_req_q   <= 1'b1;
              ped_wait_q  <= 1'b1;
              press_cnt_q <= press_cnt_inc;
            end else begin
              state      <= IDLE;
              ped_wait_q <= 1'b0;
            end
          end else begin
            if (bus.tick1s) begin
              hold_cnt <= hold_cnt - 8'd1;
            end
            if (press) begin
              deferred   <= 1'b1;
              ped_wait_q <= 1'b1;
            end
          end
        end
        default: begin
          state      <= IDLE;
          deferred   <= 1'b0;
          ped_req_q  <= 1'b0;
          ped_wait_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.btn_level = btn_level_q;
  assign bus.ped_req   = ped_req_q;
  assign bus.ped_wait  = ped_wait_q;
  assign bus.press_cnt = press_cnt_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_ped_request_ctrl.sv
// Directed bench for ped_request_ctrl with a short debounce (4) and hold-off (3), plus a
// second instance with zero hold-off.
module tb_ped_request_ctrl;
  localparam int unsigned DEB  = 4;
  localparam int unsigned HOLD = 3;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_HOLDOFF = 2'd2;

  logic clk50M;
  logic Reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [7:0] exp_q[$];

  // clock / reset
  initial clk50M = 1'b0;
  always #10 clk50M = ~clk50M;

  ped_request_ctrl_if bus ();
  ped_request_ctrl_if bus0 ();

  ped_request_ctrl #(.DEBOUNCE_CYCLES(DEB), .CNT_W(3), .HOLDOFF_S(HOLD)) dut (
    .clk50M (clk50M),
    .Reset  (Reset),
    .bus    (bus)
  );

  ped_request_ctrl #(.DEBOUNCE_CYCLES(DEB), .CNT_W(3), .HOLDOFF_S(0)) dut0 (
    .clk50M (clk50M),
    .Reset  (Reset),
    .bus    (bus0)
  );

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk50M);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ack_pulse();
    bus.ped_ack = 1'b1;
    step(1);
    bus.ped_ack = 1'b0;
  endtask

  // n tick pulses with an idle cycle between; returns right after the last tick edge
  task automatic holdoff_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick1s = 1'b1;
      step(1);
      bus.tick1s = 1'b0;
      if (i < n - 1) step(1);
    end
  endtask

  task automatic release_settle();
    bus.btn_n = 1'b1;
    step(8);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_lvl"},  bus.btn_level, 8'd1);
    chk({tag, "_req"},  bus.ped_req,   8'd0);
    chk({tag, "_wait"}, bus.ped_wait,  8'd0);
    chk({tag, "_cnt"},  bus.press_cnt, 8'd0);
    chk({tag, "_st"},   bus.dbg_state, ST_IDLE);
  endtask

  initial begin
    logic [7:0] sat;
    Reset = 1'b1;
    bus.btn_n = 1'b1;  bus.tick1s = 1'b0;  bus.ped_ack = 1'b0;
    bus0.btn_n = 1'b1; bus0.tick1s = 1'b0; bus0.ped_ack = 1'b0;
    step(3);
    chk_reset_outputs("rst");
    Reset = 1'b0;
    step(1);

    // bounce: 3 low, 1 high, 3 low -> never accepted
    bus.btn_n = 1'b0; step(3);
    bus.btn_n = 1'b1; step(1);
    bus.btn_n = 1'b0; step(3);
    bus.btn_n = 1'b1; step(8);
    chk("bounce_lvl", bus.btn_level, 8'd1);
    chk("bounce_req", bus.ped_req,   8'd0);
    chk("bounce_cnt", bus.press_cnt, 8'd0);

    // clean press: level after edge 5, request after edge 6
    bus.btn_n = 1'b0;
    step(5);
    chk("t1_lvl_e4", bus.btn_level, 8'd1);
    step(1);
    chk("t1_lvl_e5", bus.btn_level, 8'd0);
    chk("t1_req_e5", bus.ped_req,   8'd0);
    step(1);
    chk("t1_req_e6",  bus.ped_req,   8'd1);
    chk("t1_wait_e6", bus.ped_wait,  8'd1);
    chk("t1_cnt",     bus.press_cnt, 8'd1);
    chk("t1_st",      bus.dbg_state, ST_PENDING);
    step(10);
    chk("t1_hold_cnt", bus.press_cnt, 8'd1);
    release_settle();
    chk("t1_rel_lvl", bus.btn_level, 8'd1);
    chk("t1_rel_cnt", bus.press_cnt, 8'd1);
    chk("t1_rel_req", bus.ped_req,   8'd1);

    // ack and hold-off
    ack_pulse();
    chk("t3_req_ack", bus.ped_req,   8'd0);
    chk("t3_wait",    bus.ped_wait,  8'd0);
    chk("t3_st",      bus.dbg_state, ST_HOLDOFF);
    step(5);
    chk("t3_notick", bus.dbg_state, ST_HOLDOFF);
    holdoff_ticks(HOLD);
    chk("t3_zero_st", bus.dbg_state, ST_HOLDOFF);
    step(1);
    chk("t3_exit_st",  bus.dbg_state, ST_IDLE);
    chk("t3_exit_req", bus.ped_req,   8'd0);
    bus.btn_n = 1'b0;
    step(7);
    chk("t3_new_req", bus.ped_req,   8'd1);
    chk("t3_new_cnt", bus.press_cnt, 8'd2);
    release_settle();

    // deferred press during hold-off
    ack_pulse();
    bus.btn_n = 1'b0;
    step(7);
    chk("t4_wait", bus.ped_wait,  8'd1);
    chk("t4_req",  bus.ped_req,   8'd0);
    chk("t4_st",   bus.dbg_state, ST_HOLDOFF);
    chk("t4_cnt",  bus.press_cnt, 8'd2);
    release_settle();
    holdoff_ticks(HOLD);
    chk("t4_pre_req", bus.ped_req, 8'd0);
    step(1);
    chk("t4_exp_req",  bus.ped_req,   8'd1);
    chk("t4_exp_cnt",  bus.press_cnt, 8'd3);
    chk("t4_exp_wait", bus.ped_wait,  8'd1);

    // press in the same cycle as ack
    bus.btn_n = 1'b0;
    step(6);
    chk("t5_lvl", bus.btn_level, 8'd0);
    ack_pulse();
    chk("t5_st",   bus.dbg_state, ST_HOLDOFF);
    chk("t5_wait", bus.ped_wait,  8'd1);
    chk("t5_req",  bus.ped_req,   8'd0);
    chk("t5_cnt",  bus.press_cnt, 8'd3);
    release_settle();
    holdoff_ticks(HOLD);
    step(1);
    chk("t5_exp_req", bus.ped_req,   8'd1);
    chk("t5_exp_cnt", bus.press_cnt, 8'd4);

    // reset in PENDING
    Reset = 1'b1; step(1); Reset = 1'b0;
    chk_reset_outputs("t6p");

    // reset in HOLDOFF with a deferral, button held across reset
    bus.btn_n = 1'b0; step(7);
    chk("t6_req", bus.ped_req, 8'd1);
    release_settle();
    ack_pulse();
    bus.btn_n = 1'b0; step(7);
    chk("t6_defer_wait", bus.ped_wait, 8'd1);
    Reset = 1'b1; step(1); Reset = 1'b0;
    chk_reset_outputs("t6h");
    step(6);
    chk("t6_held_req_e5", bus.ped_req, 8'd0);
    step(1);
    chk("t6_held_req_e6", bus.ped_req,   8'd1);
    chk("t6_held_cnt",    bus.press_cnt, 8'd1);
    release_settle();

    // saturation after 300 requests
    Reset = 1'b1; step(1); Reset = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      sat = (i > 255) ? 8'd255 : 8'(i);
      exp_q.push_back(sat);
      bus.btn_n = 1'b0;
      for (int k = 0; k < 20 && bus.ped_req !== 1'b1; k++) step(1);
      chk("sat_req", bus.ped_req, 8'd1);
      chk("sat_cnt", bus.press_cnt, exp_q.pop_front());
      ack_pulse();
      bus.btn_n = 1'b1;
      bus.tick1s = 1'b1;
      for (int k = 0; k < 30 && !(bus.dbg_state === ST_IDLE && bus.btn_level === 1'b1); k++) step(1);
      bus.tick1s = 1'b0;
      if (i == 300) chk("sat_idle", bus.dbg_state, ST_IDLE);
    end

    // zero hold-off instance: HOLDOFF lasts one cycle
    bus0.btn_n = 1'b0;
    step(7);
    chk("h0_req", bus0.ped_req, 8'd1);
    bus0.ped_ack = 1'b1; step(1); bus0.ped_ack = 1'b0;
    chk("h0_st_hold", bus0.dbg_state, ST_HOLDOFF);
    step(1);
    chk("h0_st_idle", bus0.dbg_state, ST_IDLE);
    chk("h0_cnt",     bus0.press_cnt, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
